alt_cmd_gen: RTL and testbench
==============================

Name: alt_cmd_gen

Overview:
Altitude-hold commander that produces the 3-bit altcmd code consumed by altctrl, which maps it to rotor RPM (base 3000, step 300). It accepts measured/target altitude samples over a valid/ready handshake and converts the altitude error to a signed climb level of -3..+3. The level is slew-limited to one step per HOLD_CYCLES, and a watchdog fails safe to hover if samples stop arriving.

Parameters:
ALT_W, 16, altitude sample width (unsigned)
T1, 16, error magnitude threshold for level 1
T2, 64, error magnitude threshold for level 2
T3, 256, error magnitude threshold for level 3
HOLD_CYCLES, 4, minimum cycles between altcmd level changes (>=1)
TIMEOUT_CYCLES, 1000, cycles without an accepted sample before failsafe
HYST, 8, hysteresis margin (used only with ALT_HYST_EN)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
arm  in  1  1 = tracking enabled
alt_valid  in  1  sample valid
alt_ready  out  1  sample accepted when alt_valid & alt_ready
meas_alt  in  ALT_W  measured altitude
target_alt  in  ALT_W  target altitude, sampled together with meas_alt
altcmd  out  3  to altctrl: bit2 = descend, bits[1:0] = magnitude
failsafe  out  1  watchdog expired
at_target  out  1  desired level = 0 and current level = 0

Behaviour:
- Reset (async, immediate): state DISARMED, cur_level = 0, desired_level = 0, hold_cnt = 0, wdog = 0. Outputs: altcmd = 000, alt_ready = 0, failsafe = 0, at_target = 1.
- Encoding: level +k -> {0,k}; level -k -> {1,k}; level 0 -> 000. Code 100 is never emitted.
- Error: err = {0,target_alt} - {0,meas_alt}, ALT_W+1 bits, signed, cannot overflow.
- Magnitude: |err| < T1 -> 0; < T2 -> 1; < T3 -> 2; else 3. Sign is + when err > 0 (climb).
- FSM states:
  - DISARMED: alt_ready = 0; desired_level forced to 0. Goes to TRACK when arm = 1.
  - TRACK: alt_ready = 1. An accepted sample registers desired_level on the accept edge (E0). Goes to FAILSAFE when wdog reaches TIMEOUT_CYCLES-1 with no accept. Goes to DISARMED when arm = 0.
  - FAILSAFE: alt_ready = 1; failsafe = 1; desired_level forced to 0. An accepted sample returns to TRACK and loads desired_level from that sample. Goes to DISARMED when arm = 0.
- Watchdog: wdog clears on accept or in DISARMED, otherwise increments and saturates. An accept in the same cycle as expiry wins: stay in TRACK, wdog cleared.
- Slew: when cur_level != desired_level and hold_cnt = 0, cur_level moves one step toward desired_level and hold_cnt loads HOLD_CYCLES-1. Otherwise hold_cnt decrements to 0.
  - A zero crossing passes through 0: +1 -> 0 -> -1, each step separately held.
- Latency: altcmd is a direct encode of the cur_level register. A sample accepted at edge E0 gives its first altcmd change after edge E1, provided hold_cnt = 0.
- Disarm mid-ramp: the ramp to 0 continues at the slew rate (no step to hover).
- New sample mid-ramp: retargets desired_level. The ramp continues from cur_level and hold_cnt is not reset.

Optional Feature:
ALT_HYST_EN
- Defined: a new sample with the same sign and a smaller magnitude than the current desired_level only lowers desired_level when |err| < T_k - HYST. T_k is the lower threshold of the current desired magnitude k (T1, T2 or T3). Otherwise desired_level is held. Sign changes and increases are always accepted.
- Undefined: plain thresholds; HYST is unused.

Test Plan:
1. Reset, arm = 1, sample target = 1000, meas = 1000 -> altcmd = 000, at_target = 1, alt_ready = 1, failsafe = 0.
2. Sample target = 1500, meas = 1000 (err 500) -> altcmd 001 after E1, 010 at +4 cycles, 011 at +8 cycles; at_target = 0.
3. From 011, sample err = -300 -> altcmd 010, 001, 000, 101, 110, 111, exactly 4 cycles apart; 100 never observed.
4. TIMEOUT_CYCLES = 20, no samples -> failsafe = 1 after 20 cycles, altcmd ramps to 000. A new sample (err 100) clears failsafe, altcmd ramps to 010.
5. arm = 0 while at 011, alt_valid = 1 -> no accept (alt_ready = 0), altcmd 010, 001, 000 at 4-cycle spacing. Async resetn low mid-ramp -> altcmd = 000 without a clock edge.
6. With ALT_HYST_EN: err 70 -> level 2; err 60 -> stays 010 (60 >= 56); err 50 -> ramps to 001. Without the macro, err 60 -> 001.

Source files
------------

// File: rtl/alt_cmd_gen.sv
// Altitude-hold commander: altitude error -> slew-limited climb level -3..+3 -> 3-bit altcmd.
// Define ALT_HYST_EN to add a hysteresis margin (HYST) before desired_level is allowed to drop.
module alt_cmd_gen #(
  parameter int ALT_W          = 16,
  parameter int T1             = 16,
  parameter int T2             = 64,
  parameter int T3             = 256,
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int HYST           = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             arm,
  input  logic             alt_valid,
  output logic             alt_ready,
  input  logic [ALT_W-1:0] meas_alt,
  input  logic [ALT_W-1:0] target_alt,
  output logic [2:0]       altcmd,
  output logic             failsafe,
  output logic             at_target
);

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_TRACK    = 2'd1;
  localparam logic [1:0] ST_FAILSAFE = 2'd2;

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT_CYCLES - 1);

`ifdef ALT_HYST_EN
  localparam int MARGIN = HYST;
`else
  // Zero margin makes the hold test below unreachable, i.e. plain thresholds.
  localparam int MARGIN = 0 * HYST;
`endif

  localparam logic [ALT_W:0] TH1 = (ALT_W+1)'(T1);
  localparam logic [ALT_W:0] TH2 = (ALT_W+1)'(T2);
  localparam logic [ALT_W:0] TH3 = (ALT_W+1)'(T3);
  localparam logic [ALT_W:0] HT1 = (T1 > MARGIN) ? (ALT_W+1)'(T1 - MARGIN) : '0;
  localparam logic [ALT_W:0] HT2 = (T2 > MARGIN) ? (ALT_W+1)'(T2 - MARGIN) : '0;
  localparam logic [ALT_W:0] HT3 = (T3 > MARGIN) ? (ALT_W+1)'(T3 - MARGIN) : '0;

  logic [1:0]        state_q, state_d;
  logic signed [2:0] cur_q, cur_d;
  logic signed [2:0] desired_q, desired_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [WW-1:0]     wdog_q, wdog_d, wdog_inc;

  logic signed [ALT_W:0] err;
  logic [ALT_W:0]        mag;
  logic [ALT_W:0]        hyst_th;
  logic [1:0]            raw_mag, des_mag, cur_mag;
  logic signed [2:0]     raw_level, sample_level;
  logic                  hold_desired;
  logic                  accept;

  assign err = $signed({1'b0, target_alt}) - $signed({1'b0, meas_alt});
  assign mag = err[ALT_W] ? (ALT_W+1)'(-err) : err;

  always_comb begin
    if (mag < TH1)      raw_mag = 2'd0;
    else if (mag < TH2) raw_mag = 2'd1;
    else if (mag < TH3) raw_mag = 2'd2;
    else                raw_mag = 2'd3;
  end

  assign raw_level = err[ALT_W] ? -$signed({1'b0, raw_mag}) : $signed({1'b0, raw_mag});
  assign des_mag   = desired_q[2] ? 2'(-desired_q) : desired_q[1:0];

  always_comb begin
    case (des_mag)
      2'd1:    hyst_th = HT1;
      2'd2:    hyst_th = HT2;
      2'd3:    hyst_th = HT3;
      default: hyst_th = '0;
    endcase
  end

  // Same-direction decrease is refused until the error is clearly inside the lower band.
  assign hold_desired = (des_mag != 2'd0) && (desired_q[2] == err[ALT_W]) &&
                        (raw_mag < des_mag) && (mag >= hyst_th);
  assign sample_level = hold_desired ? desired_q : raw_level;

  // Gated by arm so a sample offered in the disarm cycle is never taken.
  assign alt_ready = arm && (state_q != ST_DISARMED);
  assign accept    = alt_valid && alt_ready;
  assign wdog_inc  = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    desired_d = desired_q;
    wdog_d    = wdog_q;
    case (state_q)
      ST_DISARMED: begin
        desired_d = '0;
        wdog_d    = '0;
        if (arm) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        if (!arm) begin
          state_d   = ST_DISARMED;
          desired_d = '0;
          wdog_d    = '0;
        end else if (accept) begin
          desired_d = sample_level;
          wdog_d    = '0;
        end else if (wdog_q == WDOG_MAX) begin
          state_d   = ST_FAILSAFE;
          desired_d = '0;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      ST_FAILSAFE: begin
        if (!arm) begin
          state_d   = ST_DISARMED;
          desired_d = '0;
          wdog_d    = '0;
        end else if (accept) begin
          state_d   = ST_TRACK;
          desired_d = sample_level;
          wdog_d    = '0;
        end else begin
          desired_d = '0;
          wdog_d    = wdog_inc;
        end
      end
      default: begin
        state_d   = ST_DISARMED;
        desired_d = '0;
        wdog_d    = '0;
      end
    endcase
  end

  // Slew toward the registered target one step at a time; zero crossings pass through 0.
  always_comb begin
    cur_d  = cur_q;
    hold_d = hold_q;
    if ((cur_q != desired_q) && (hold_q == '0)) begin
      cur_d  = (desired_q > cur_q) ? cur_q + 3'sd1 : cur_q - 3'sd1;
      hold_d = HOLD_MAX;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_DISARMED;
      cur_q     <= '0;
      desired_q <= '0;
      hold_q    <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      desired_q <= desired_d;
      hold_q    <= hold_d;
      wdog_q    <= wdog_d;
    end
  end

  assign cur_mag   = cur_q[2] ? 2'(-cur_q) : cur_q[1:0];
  assign altcmd    = {cur_q[2], cur_mag};
  assign failsafe  = (state_q == ST_FAILSAFE);
  assign at_target = (desired_q == 3'sd0) && (cur_q == 3'sd0);

endmodule

// File: tb/tb_alt_cmd_gen.sv
// Scoreboard bench for alt_cmd_gen: expected altcmd steps (code + cycle) are queued by
// the stimulus and popped by a monitor whenever altcmd changes.
module tb_alt_cmd_gen;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        arm = 1'b0;
  logic        alt_valid = 1'b0;
  logic        alt_ready;
  logic [15:0] meas_alt = '0;
  logic [15:0] target_alt = '0;
  logic [2:0]  altcmd;
  logic        failsafe;
  logic        at_target;

  alt_cmd_gen #(
    .ALT_W(16), .T1(16), .T2(64), .T3(256),
    .HOLD_CYCLES(4), .TIMEOUT_CYCLES(TO), .HYST(8)
  ) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .alt_valid(alt_valid), .alt_ready(alt_ready),
    .meas_alt(meas_alt), .target_alt(target_alt), .altcmd(altcmd),
    .failsafe(failsafe), .at_target(at_target)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [2:0]  exp_code_q[$];
  int          exp_cyc_q[$];
  bit          mon_en = 1'b0;
  bit          keep = 1'b0;
  logic [15:0] last_t = '0;
  logic [15:0] last_m = '0;
  int          last_acc = 0;
  int          a, b, f, d, e, h, i6, j6, k6;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("[TB] cyc %0d check %s = %0h ok", cyc, name, act);
    end
  endtask

  task automatic push(input logic [2:0] code, input int c);
    exp_code_q.push_back(code);
    exp_cyc_q.push_back(c);
  endtask

  // Called at posedge+1; consumes exactly one clock edge (the accept edge).
  task automatic send(input logic [15:0] t, input logic [15:0] m);
    target_alt = t;
    meas_alt   = m;
    alt_valid  = 1'b1;
    chk("alt_ready_on_send", {31'd0, alt_ready}, 32'd1);
    @(posedge clk);
    #1;
    alt_valid = 1'b0;
    last_acc  = cyc;
    last_t    = t;
    last_m    = m;
    $display("[TB] cyc %0d sample accepted target=%0d meas=%0d", cyc, t, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if (keep && (i % 8 == 7)) send(last_t, last_m);
      else begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Monitor: every altcmd change must match the head of the scoreboard, value and cycle.
  initial begin
    logic [2:0] prev_cmd;
    logic [2:0] ecode;
    int         ecyc;
    prev_cmd = 3'b000;
    forever begin
      @(negedge clk);
      if (mon_en && (altcmd !== prev_cmd)) begin
        n_tests++;
        if (exp_code_q.size() == 0) begin
          n_fail++;
          $display("FAIL altcmd_step: got %b at cycle %0d, expected no change", altcmd, cyc);
        end else begin
          ecode = exp_code_q.pop_front();
          ecyc  = exp_cyc_q.pop_front();
          if ((altcmd !== ecode) || (cyc != ecyc)) begin
            n_fail++;
            $display("FAIL altcmd_step: got %b at cycle %0d, expected %b at cycle %0d",
                     altcmd, cyc, ecode, ecyc);
          end else begin
            $display("[TB] cyc %0d altcmd step %b ok", cyc, altcmd);
          end
        end
        prev_cmd = altcmd;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    resetn = 1'b0;
    arm    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_altcmd", {29'd0, altcmd}, 32'd0);
    chk("reset_alt_ready", {31'd0, alt_ready}, 32'd0);
    chk("reset_failsafe", {31'd0, failsafe}, 32'd0);
    chk("reset_at_target", {31'd0, at_target}, 32'd1);
    resetn = 1'b1;
    arm    = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // 1: on-target sample
    send(16'd1000, 16'd1000);
    chk("t1_at_target", {31'd0, at_target}, 32'd1);
    chk("t1_alt_ready", {31'd0, alt_ready}, 32'd1);
    chk("t1_failsafe", {31'd0, failsafe}, 32'd0);
    chk("t1_altcmd", {29'd0, altcmd}, 32'd0);

    // 2: err +500 ramps 001, 010, 011 at 4-cycle spacing
    keep = 1'b1;
    send(16'd1500, 16'd1000);
    a = last_acc;
    push(3'b001, a + 1);
    push(3'b010, a + 5);
    push(3'b011, a + 9);
    idle(12);
    chk("t2_at_target", {31'd0, at_target}, 32'd0);

    // 3: err -300 crosses zero one step at a time
    send(16'd1000, 16'd1300);
    b = last_acc;
    push(3'b010, b + 1);
    push(3'b001, b + 5);
    push(3'b000, b + 9);
    push(3'b101, b + 13);
    push(3'b110, b + 17);
    push(3'b111, b + 21);
    idle(26);

    // 4: samples stop -> failsafe, ramp to hover; new sample recovers
    keep = 1'b0;
    f = last_acc + TO;
    push(3'b110, f + 1);
    push(3'b101, f + 5);
    push(3'b000, f + 9);
    idle(f - 1 - cyc);
    chk("t4_failsafe_before", {31'd0, failsafe}, 32'd0);
    idle(1);
    chk("t4_failsafe_expired", {31'd0, failsafe}, 32'd1);
    chk("t4_ready_in_failsafe", {31'd0, alt_ready}, 32'd1);
    idle(12);
    chk("t4_at_target_hover", {31'd0, at_target}, 32'd1);
    send(16'd1100, 16'd1000);
    d = last_acc;
    chk("t4_failsafe_cleared", {31'd0, failsafe}, 32'd0);
    push(3'b001, d + 1);
    push(3'b010, d + 5);

    // 5: disarm at 011 with a sample offered -> no accept, ramp down
    idle(8);
    send(16'd1500, 16'd1000);
    e = last_acc;
    push(3'b011, e + 1);
    idle(5);
    arm        = 1'b0;
    target_alt = 16'd1500;
    meas_alt   = 16'd1000;
    alt_valid  = 1'b1;
    #1;
    chk("t5_ready_disarmed", {31'd0, alt_ready}, 32'd0);
    push(3'b010, e + 7);
    push(3'b001, e + 11);
    push(3'b000, e + 15);
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
    end
    alt_valid = 1'b0;
    chk("t5_ready_still_low", {31'd0, alt_ready}, 32'd0);
    chk("t5_at_target", {31'd0, at_target}, 32'd1);

    // 5b: asynchronous reset mid-ramp
    arm = 1'b1;
    idle(2);
    send(16'd1500, 16'd1000);
    h = last_acc;
    push(3'b001, h + 1);
    push(3'b010, h + 5);
    idle(6);
    push(3'b000, h + 6);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_async_altcmd", {29'd0, altcmd}, 32'd0);
    chk("t5_async_ready", {31'd0, alt_ready}, 32'd0);
    chk("t5_async_at_target", {31'd0, at_target}, 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);

    // 6: hysteresis behaviour (err 70 -> 2, then 60, then 50)
    send(16'd1070, 16'd1000);
    i6 = last_acc;
    push(3'b001, i6 + 1);
    push(3'b010, i6 + 5);
    idle(8);
    send(16'd1060, 16'd1000);
    j6 = last_acc;
`ifndef ALT_HYST_EN
    push(3'b001, j6 + 1);
`endif
    idle(8);
    send(16'd1050, 16'd1000);
    k6 = last_acc;
`ifdef ALT_HYST_EN
    push(3'b001, k6 + 1);
`endif
    idle(8);
    chk("t6_altcmd_final", {29'd0, altcmd}, 32'd1);
    chk("t6_at_target", {31'd0, at_target}, 32'd0);

    chk("scoreboard_drained", exp_code_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
